tx_module: RTL and testbench

TX_MODULE -- requirements
Module: tx_module

---
 rtl/uart_pkg.sv | 31 +++
 rtl/tx_module.sv | 163 ++++++++++++++++
 tb/tb_tx_module.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter (tx_module) and the
// receiver: FSM state encoding, default oversample ratio and a parity helper.
//
// Optional feature macro: TX_PARITY_EN
//   When defined, the state encoding gains ST_PARITY (even-parity bit slot
//   between the data bits and the stop bit).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Ticks per serial bit period; the receiver uses the same ratio.
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } uart_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tx_module.sv
// -----------------------------------------------------------------------------
// tx_module
// UART transmitter. Serialises one byte per frame: start bit (0), 8 data bits
// LSB first, optional even-parity bit, one stop bit (1). Every bit lasts
// exactly OVERSAMPLE pulses of the external tick strobe; this block contains
// no baud divider of its own.
//
// Optional feature macro: TX_PARITY_EN
//   Defined   : frame = start + 8 data + parity + stop (11 bit periods).
//   Undefined : frame = start + 8 data + stop (10 bit periods).
//
// Parameters
//   OVERSAMPLE : ticks per serial bit period (default from uart_pkg)
//
// Ports
//   clk      in  1  system clock, rising edge
//   rst      in  1  synchronous active-high reset (aborts any frame)
//   tick     in  1  one-cycle oversample strobe
//   tx_start in  1  request to send txdata (honoured only when idle)
//   txdata   in  8  byte to send, captured on acceptance
//   tx       out 1  serial line, idle high
//   tx_busy  out 1  high from acceptance until frame end
//   tx_done  out 1  one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module tx_module
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       tx_start,
    input  logic [7:0] txdata,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // A ratio of 1 would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    uart_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
`ifdef TX_PARITY_EN
    logic             r_par;
`endif

    // Final tick of the current bit period.
    logic w_bit_end;
    assign w_bit_end = tick && (r_cnt == CNT_LAST);

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= 8'hFF;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    // A tick coinciding with acceptance is deliberately not
                    // counted: the counter starts from zero in ST_START.
                    if (tx_start) begin
                        r_shift <= txdata;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
`ifdef TX_PARITY_EN
                        r_par   <= even_parity(txdata);
`endif
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 4'd7) begin
`ifdef TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            // Next bit is shift[1]; refill with ones so the
                            // register drains back to its idle value.
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b1, r_shift[7:1]};
                        end
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    // Busy drops with the done pulse so a request present in
                    // that same cycle is accepted on the next edge.
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_module.sv
module tb_tx_module;

    localparam int OS = 16;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP_A5 = 11'h54A;
    localparam logic [10:0] EXP_0F = 11'h41E;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_A5 = 11'h34A;
    localparam logic [10:0] EXP_0F = 11'h21E;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;
    int tcnt   = 0;
    bit chk_en = 1'b0;
    bit rx_en  = 1'b0;
    byte unsigned rx_q[$];

    // Frame-level reference model
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_tx    = 1'b1;
    int          m_ticks = 0;
    logic [10:0] m_frame = '1;

    tx_module #(.OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tx_start (tx_start),
        .txdata   (txdata),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Tick strobe every 4 clocks, changed 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        tick = (tcnt % 4 == 0);
        tcnt++;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is a bit vector; bit index = ticks counted / OS
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_tx   = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == NB * OS) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_tx   = 1'b1;
                    end else begin
                        m_tx = m_frame[m_ticks / OS];
                    end
                end
            end else if (tx_start) begin
                m_frame = frame_of(txdata);
                m_ticks = 0;
                m_busy  = 1'b1;
                m_tx    = 1'b0;
            end else begin
                m_tx = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tx", tx, m_tx);
            chk("model_busy", tx_busy, m_busy);
            chk("model_done", tx_done, m_done);
        end
        if (tx_done === 1'b1) n_done++;
    end

    // Behavioural receiver sampling mid-bit (64 clocks per bit)
    always begin
        logic [7:0] b;
        @(negedge clk);
        if (rx_en && tx === 1'b0) begin
            repeat (32) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (64) @(negedge clk);
                b[i] = tx;
            end
`ifdef TX_PARITY_EN
            repeat (64) @(negedge clk);
`endif
            repeat (64) @(negedge clk);
            rx_q.push_back(b);
        end
    end

    // Called at a negedge; samples each bit of a frame near its centre.
    task automatic sample_frame(output logic [10:0] bits, input bit poke);
        bit found = 1'b0;
        bits = '0;
        for (int i = 0; i < 300; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_chk++;
            n_err++;
            $display("FAIL frame_start: tx stayed %0b, required 0", tx);
            return;
        end
        repeat (32) @(negedge clk);
        bits[0] = tx;
        for (int k = 1; k < NB; k++) begin
            if (poke && k == 3) begin
                tx_start = 1'b1;
                txdata   = 8'h00;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (63) @(negedge clk);
            end else begin
                repeat (64) @(negedge clk);
            end
            bits[k] = tx;
        end
    endtask

    task automatic wait_done(input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: tx_done never seen, got 0 required 1", nm);
        end
    endtask

    task automatic send_at_posedge(input logic [7:0] d);
        @(posedge clk);
        #1;
        txdata   = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] bits;
        int d0;
        logic [7:0] lb [3];
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h3C;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done, 1'b0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A5 frame, with an ignored request (data 00) in the middle
        d0 = n_done;
        send_at_posedge(8'hA5);
        chk("start_latency_tx", tx, 1'b0);
        chk("start_latency_busy", tx_busy, 1'b1);
        sample_frame(bits, 1'b1);
        chk("frame_A5", 32'(bits), 32'(EXP_A5));
        wait_done("done_A5");
        repeat (5) @(negedge clk);
        #1;
        chk("done_count_A5", n_done - d0, 1);
        chk("idle_after_A5", tx_busy, 1'b0);

        // Held tx_start: 55 then 0F back-to-back
        @(posedge clk);
        #1;
        txdata   = 8'h55;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        txdata = 8'h0F;
        @(negedge clk);
        wait_done("done_55");
        @(negedge clk);
        chk("b2b_start_tx", tx, 1'b0);
        chk("b2b_start_busy", tx_busy, 1'b1);
        tx_start = 1'b0;
        sample_frame(bits, 1'b0);
        chk("frame_0F", 32'(bits), 32'(EXP_0F));
        wait_done("done_0F");

        // Abort during data bit 3 of FF
        send_at_posedge(8'hFF);
        repeat (32 + 64 * 4) @(negedge clk);
        chk("abort_pre_busy", tx_busy, 1'b1);
        d0 = n_done;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        #1;
        chk("abort_no_done", n_done - d0, 0);

        // Reset wins over a simultaneous start request
        @(negedge clk);
        rst      = 1'b1;
        tx_start = 1'b1;
        txdata   = 8'h12;
        @(negedge clk);
        chk("rst_prio_busy", tx_busy, 1'b0);
        chk("rst_prio_tx", tx, 1'b1);
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prio_idle", tx_busy, 1'b0);

`ifdef TX_PARITY_EN
        send_at_posedge(8'h07);
        sample_frame(bits, 1'b0);
        chk("frame_07", 32'(bits), 32'h60E);
        chk("parity_07", bits[9], 1'b1);
        wait_done("done_07");
        send_at_posedge(8'h03);
        sample_frame(bits, 1'b0);
        chk("frame_03", 32'(bits), 32'h406);
        chk("parity_03", bits[9], 1'b0);
        wait_done("done_03");
`endif

        // Loopback through the behavioural receiver
        repeat (10) @(negedge clk);
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_start = 1'b1;
            txdata   = lb[i];
            @(negedge clk);
            tx_start = 1'b0;
            wait_done("done_loop");
            @(negedge clk);
        end
        repeat (50) @(negedge clk);
        rx_en = 1'b0;
        chk("loop_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("loop_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(lb[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
